// File: rtl/mode_s_ppm_tx.sv
// Mode S / ADS-B 1090 MHz PPM transmitter: preamble plus PPM data block at baseband.
// Optional MODE_S_TX_PARITY_EN replaces the last 24 bits with the Mode S CRC.
module mode_s_ppm_tx #(
    parameter int WIDTH_OUT = 16,
    parameter int SPC       = 10,
    parameter int GAP_CHIPS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [111:0]                msg_data,
    input  logic                        msg_long,
    input  logic [WIDTH_OUT-2:0]        amplitude,
    input  logic                        msg_valid,
    output logic                        msg_ready,
    output logic signed [WIDTH_OUT-1:0] sig_out_i,
    output logic signed [WIDTH_OUT-1:0] sig_out_q,
    output logic                        tx_active,
    output logic                        done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]           state;
    logic [5:0]           samp;
    logic [7:0]           chip;
    logic [111:0]         shreg;
    logic                 is_long;
    logic [WIDTH_OUT-2:0] amp;

    logic accept;
    logic chip_end;
    logic last_data;
    logic gap_end;
    logic data_bit;
    logic level;

    assign accept    = msg_valid && msg_ready && (state == S_IDLE);
    assign chip_end  = (samp == 6'(SPC - 1));
    assign last_data = (state == S_DATA) && chip_end &&
                       (chip == (is_long ? 8'd223 : 8'd111));
    // The gap is one cycle short of GAP_CHIPS*SPC because the IDLE cycle
    // in which the next accept happens supplies the final zero sample.
    assign gap_end   = (state == S_GAP) && (chip == 8'(GAP_CHIPS - 1)) &&
                       (samp == 6'(SPC - 2));

`ifdef MODE_S_TX_PARITY_EN
    logic [23:0] crc;
    logic [6:0]  bit_idx;
    logic        in_par;

    assign bit_idx  = chip[7:1];
    assign in_par   = bit_idx >= (is_long ? 7'd88 : 7'd32);
    assign data_bit = in_par ? crc[23] : shreg[111];

    // Bit-serial CRC over the message bits, then shifted out as parity
    always_ff @(posedge clk) begin
        if (reset) begin
            crc <= '0;
        end else if (accept) begin
            crc <= '0;
        end else if (state == S_DATA && chip_end && chip[0]) begin
            if (in_par)
                crc <= {crc[22:0], 1'b0};
            else if (shreg[111] ^ crc[23])
                crc <= {crc[22:0], 1'b0} ^ 24'hFFF409;
            else
                crc <= {crc[22:0], 1'b0};
        end
    end
`else
    assign data_bit = shreg[111];
`endif

    // Pulse level of the sample currently being produced
    always_comb begin
        level = 1'b0;
        unique case (state)
            S_PRE:  level = (chip == 8'd0) || (chip == 8'd2) ||
                            (chip == 8'd7) || (chip == 8'd9);
            S_DATA: level = data_bit ^ chip[0];
            default: level = 1'b0;
        endcase
    end

    // Frame sequencer: state, sample/chip counters and message latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            samp      <= '0;
            chip      <= '0;
            shreg     <= '0;
            is_long   <= 1'b0;
            amp       <= '0;
            msg_ready <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_PRE;
                        shreg     <= msg_data;
                        is_long   <= msg_long;
                        amp       <= amplitude;
                        samp      <= '0;
                        chip      <= '0;
                        msg_ready <= 1'b0;
                    end else begin
                        msg_ready <= 1'b1;
                    end
                end
                S_PRE: begin
                    samp <= chip_end ? 6'd0 : samp + 6'd1;
                    if (chip_end) begin
                        if (chip == 8'd15) begin
                            chip  <= '0;
                            state <= S_DATA;
                        end else begin
                            chip <= chip + 8'd1;
                        end
                    end
                end
                S_DATA: begin
                    samp <= chip_end ? 6'd0 : samp + 6'd1;
                    if (chip_end) begin
                        if (chip[0])
                            shreg <= {shreg[110:0], 1'b0};
                        if (last_data) begin
                            chip <= '0;
                            if (GAP_CHIPS == 0) begin
                                state     <= S_IDLE;
                                msg_ready <= 1'b1;
                            end else begin
                                state <= S_GAP;
                            end
                        end else begin
                            chip <= chip + 8'd1;
                        end
                    end
                end
                default: begin
                    if (gap_end) begin
                        state     <= S_IDLE;
                        samp      <= '0;
                        chip      <= '0;
                        msg_ready <= 1'b1;
                    end else begin
                        samp <= chip_end ? 6'd0 : samp + 6'd1;
                        if (chip_end)
                            chip <= chip + 8'd1;
                    end
                end
            endcase
        end
    end

    // Registered output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_out_i <= '0;
            tx_active <= 1'b0;
            done      <= 1'b0;
        end else begin
            sig_out_i <= level ? $signed({1'b0, amp}) : '0;
            tx_active <= (state == S_PRE) || (state == S_DATA);
            done      <= last_data;
        end
    end

    assign sig_out_q = '0;

endmodule

// File: tb/tb_mode_s_ppm_tx.sv
// Self-checking bench for mode_s_ppm_tx against a sample-level frame model.
// Honours MODE_S_TX_PARITY_EN the same way as the design.
module tb_mode_s_ppm_tx;
    localparam int W   = 16;
    localparam int SPC = 10;
    localparam int GAP = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [111:0]        msg_data;
    logic                msg_long;
    logic [W-2:0]        amplitude;
    logic                msg_valid;
    logic                msg_ready;
    logic signed [W-1:0] sig_out_i;
    logic signed [W-1:0] sig_out_q;
    logic                tx_active;
    logic                done;

    int ncmp  = 0;
    int nfail = 0;

    logic [W-1:0] samples [0:2999];
    logic [111:0] last_dec;

    mode_s_ppm_tx #(.WIDTH_OUT(W), .SPC(SPC), .GAP_CHIPS(GAP)) dut (
        .clk(clk), .reset(reset), .msg_data(msg_data), .msg_long(msg_long),
        .amplitude(amplitude), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .sig_out_i(sig_out_i), .sig_out_q(sig_out_q), .tx_active(tx_active),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitted bit sequence, MSB-aligned in a 112-bit vector.
    function automatic logic [111:0] frame_bits(input logic [111:0] d,
                                                input logic l);
        logic [111:0] r;
        int n;
        n = l ? 112 : 56;
        r = '0;
        for (int i = 0; i < n; i++) r[111-i] = d[111-i];
`ifdef MODE_S_TX_PARITY_EN
        begin
            logic        m [0:111];
            logic [24:0] g;
            g = 25'h1FFF409;
            for (int i = 0; i < n; i++) m[i] = (i < n - 24) ? d[111-i] : 1'b0;
            for (int i = 0; i < n - 24; i++)
                if (m[i])
                    for (int j = 0; j < 25; j++) m[i+j] = m[i+j] ^ g[24-j];
            for (int i = n - 24; i < n; i++) r[111-i] = m[i];
        end
`endif
        return r;
    endfunction

    function automatic logic exp_high(input logic [111:0] eb, input int k);
        int c;
        int d;
        c = k / SPC;
        if (c < 16) return (c == 0) || (c == 2) || (c == 7) || (c == 9);
        d = c - 16;
        if (d % 2 == 0) return eb[111 - d/2];
        return !eb[111 - d/2];
    endfunction

    // Consumes an active frame starting at the currently visible sample.
    task automatic collect(input string tag, input logic [111:0] d,
                           input logic l, input logic [W-2:0] a);
        logic [111:0] eb;
        logic [111:0] dec;
        logic [W-1:0] ev;
        int n, flen, len, bad, firstbad, doneidx, donecnt, qbad, rdybad, c;
        eb = frame_bits(d, l);
        n = l ? 112 : 56;
        flen = SPC * (16 + 2 * n);
        len = 0; bad = 0; firstbad = -1; doneidx = -1;
        donecnt = 0; qbad = 0; rdybad = 0;
        dec = '0;
        while (tx_active === 1'b1 && len < 3000) begin
            ev = exp_high(eb, len) ? {1'b0, a} : '0;
            samples[len] = sig_out_i;
            if (sig_out_i !== ev) begin
                bad++;
                if (firstbad < 0) firstbad = len;
            end
            if (sig_out_q !== '0) qbad++;
            if (msg_ready !== 1'b0) rdybad++;
            if (done === 1'b1) begin
                donecnt++;
                doneidx = len;
            end
            c = len / SPC;
            if (c >= 16 && ((c - 16) % 2 == 0) && (len % SPC == SPC / 2))
                dec[111 - (c - 16) / 2] = (sig_out_i != 0);
            len++;
            @(posedge clk); #1;
        end
        last_dec = dec;
        check({tag, " length"}, len, flen);
        check({tag, " samples_bad"}, bad, 0);
        if (bad != 0) check({tag, " first_bad_idx"}, firstbad, -1);
        check({tag, " done_idx"}, doneidx, flen - 1);
        check({tag, " done_count"}, donecnt, 1);
        check({tag, " q_nonzero"}, qbad, 0);
        check({tag, " ready_busy"}, rdybad, 0);
        check({tag, " decoded"}, dec, eb);
        check({tag, " done_after"}, done, 1'b0);
    endtask

    // Present a message and wait for acceptance; leaves the bench at the
    // point where the first preamble sample is visible.
    task automatic send(input string tag, input logic [111:0] d,
                        input logic l, input logic [W-2:0] a,
                        input logic keep);
        int n;
        msg_data = d; msg_long = l; amplitude = a; msg_valid = 1'b1;
        n = 0;
        while (msg_ready !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " ready_timeout"}, n < 5000, 1'b1);
        @(posedge clk); #1;
        if (!keep) msg_valid = 1'b0;
        check({tag, " ready_drop"}, msg_ready, 1'b0);
        @(posedge clk); #1;
        check({tag, " tx_rise"}, tx_active, 1'b1);
    endtask

    initial begin
        logic [111:0] d1;
        logic [111:0] d2;
        logic [111:0] rd;
        logic [W-2:0] ra;
        logic         rl;
        int           zeros;
        int           dn;

        d1 = 112'h8D4840D6202CC371C32CE0576098;
        reset = 1'b1; msg_valid = 1'b1; msg_long = 1'b1;
        msg_data = d1; amplitude = 15'h7000;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rst ready", msg_ready, 1'b0);
            check("rst outs", {sig_out_i, sig_out_q, tx_active, done}, '0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst release ready", msg_ready, 1'b1);
        check("rst release idle", tx_active, 1'b0);
        msg_valid = 1'b0;
        @(posedge clk); #1;

        send("long", d1, 1'b1, 15'h7000, 1'b0);
        collect("long", d1, 1'b1, 15'h7000);
        check("long pre0", samples[0], 16'h7000);
        check("long pre25", samples[25], 16'h7000);
        check("long pre75", samples[75], 16'h7000);
        check("long pre99", samples[99], 16'h7000);
        check("long pre10", samples[10], 16'h0000);
        check("long pre50", samples[50], 16'h0000);
        check("long pre100", samples[100], 16'h0000);

        d2 = {56'h5D4840D6ABCDEF, 56'h0};
        send("short", d2, 1'b0, 15'h7000, 1'b0);
        collect("short", d2, 1'b0, 15'h7000);
        check("short s160", samples[160], 16'h0000);
        check("short s169", samples[169], 16'h0000);
        check("short s170", samples[170], 16'h7000);
        check("short s179", samples[179], 16'h7000);

        d1 = 112'h8D4840D6202CC371C32CE0000000;
        send("crc", d1, 1'b1, 15'h7000, 1'b0);
        collect("crc", d1, 1'b1, 15'h7000);
`ifdef MODE_S_TX_PARITY_EN
        check("crc last24", last_dec[23:0], 24'h576098);
`else
        check("crc last24", last_dec[23:0], 24'h000000);
`endif

        // Back-to-back with msg_valid held; inputs change mid-frame.
        d1 = {$urandom, $urandom, $urandom, 16'($urandom)};
        d2 = {$urandom, $urandom, $urandom, 16'($urandom)};
        send("b2b1", d1, 1'b1, 15'h1234, 1'b1);
        msg_data = d2; msg_long = 1'b0; amplitude = 15'h0F0F;
        collect("b2b1", d1, 1'b1, 15'h1234);
        zeros = 0;
        while (tx_active !== 1'b1 && zeros < 1000) begin
            check("b2b gap zero", sig_out_i, '0);
            zeros++;
            @(posedge clk); #1;
        end
        check("b2b gap len", zeros, GAP * SPC);
        msg_valid = 1'b0;
        collect("b2b2", d2, 1'b0, 15'h0F0F);

        for (int t = 0; t < 4; t++) begin
            rd = {$urandom, $urandom, $urandom, 16'($urandom)};
            rl = 1'($urandom_range(0, 1));
            ra = 15'($urandom_range(1, 32767));
            send("rand", rd, rl, ra, 1'b0);
            collect("rand", rd, rl, ra);
        end

        // Reset in the middle of a long frame.
        d1 = {$urandom, $urandom, $urandom, 16'($urandom)};
        send("midrst", d1, 1'b1, 15'h7000, 1'b0);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
        end
        check("midrst active", tx_active, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst outs", {sig_out_i, sig_out_q, tx_active, done}, '0);
        check("midrst ready", msg_ready, 1'b0);
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || tx_active === 1'b1) dn++;
        end
        check("midrst no done", dn, 0);
        check("midrst ready after", msg_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/mode_s_ppm_tx.md
# mode_s_ppm_tx

Mode S / ADS-B 1090 MHz pulse-position-modulation transmitter. It accepts a 56- or 112-bit Mode S message over a valid/ready handshake and emits the full reply waveform at baseband: the 8 µs preamble followed by the PPM data block, one sample per clock. It is the transmit-side counterpart of the DDC → magnitude receive chain. It drives the DUC/DAC path and serves as a loopback stimulus source for the 1090 demodulator.

## Interface
Parameters:
- WIDTH_OUT, 16, width of signed sig_out_i / sig_out_q.
- SPC, 10, samples per 0.5 µs chip (10 at the 20 MHz sample clock); legal range 2..63.
- GAP_CHIPS, 8, forced idle chips after each frame before msg_ready reasserts; 0 means no gap.

Ports:
- clk  in  1  sample clock.
- reset  in  1  synchronous, active-high reset.
- msg_data  in  112  message, MSB first; short frames use msg_data[111:56].
- msg_long  in  1  1 = 112-bit frame, 0 = 56-bit frame.
- amplitude  in  WIDTH_OUT-1  pulse amplitude (positive magnitude).
- msg_valid  in  1  message present.
- msg_ready  out  1  block can accept a message.
- sig_out_i  out  WIDTH_OUT  baseband I, signed.
- sig_out_q  out  WIDTH_OUT  baseband Q, signed; always 0.
- tx_active  out  1  high while preamble or data samples are being emitted.
- done  out  1  one-cycle pulse coincident with the last data sample.

## Operation
- States: IDLE, PREAMBLE, DATA, GAP.
- IDLE:
  - msg_ready=1.
  - On msg_valid&&msg_ready, latch msg_data, msg_long and amplitude, then go to PREAMBLE.
- PREAMBLE:
  - 16 chips.
  - Pulse (I=amplitude) during chips 0, 2, 7 and 9, i.e. 0, 1.0, 3.5 and 4.5 µs; all other chips I=0.
- DATA:
  - N=112 or 56 bits, 2 chips per bit, MSB first.
  - Bit 1 → high chip then low chip. Bit 0 → low chip then high chip.
- GAP:
  - GAP_CHIPS*SPC cycles with I=0, then go to IDLE.
  - If GAP_CHIPS=0, DATA goes straight to IDLE.
- msg_ready=0 in all states except IDLE. Inputs are ignored outside IDLE.
- Counters: a sample-in-chip counter runs 0..SPC-1, a chip counter runs 0..15 (preamble) or 0..2N-1 (data), and a bit shift register.
- A frame lasts SPC*(16+2N) samples: 2400 for long frames and 1280 for short frames at SPC=10.
- Q output is constant 0. I takes only the values 0 and +amplitude (sign bit 0).

## Timing
- Reset values: msg_ready=0 during reset, and 1 the cycle after reset deasserts (IDLE). sig_out_i=0, sig_out_q=0, tx_active=0, done=0.
- Outputs are registered. The first preamble sample appears on sig_out_i on the clock edge after the accepting edge; tx_active rises on the same edge.
- Back-to-back frames:
  - msg_ready reasserts the cycle after the last GAP sample, or the cycle after done when GAP_CHIPS=0.
  - An accept on that cycle gives exactly SPC*GAP_CHIPS zero samples between frames.
- done and the final data sample share one cycle. tx_active falls on the next edge.
- Reset mid-frame: on the next edge, outputs go to 0, state goes to IDLE and counters clear. No done is generated.
- A msg_valid held high while busy is not consumed; it is accepted on the first ready cycle.
- msg_long and amplitude changes outside acceptance have no effect on the frame in flight.

## Configuration
- MODE_S_TX_PARITY_EN defined:
  - The last 24 bits of the frame are replaced by the Mode S CRC.
  - Generator is 0x1FFF409, computed bit-serially over the first N-24 transmitted bits as they are sent.
  - Emitted bits 0..N-25 come from msg_data. Bits N-24..N-1 come from the CRC register.
  - Input parity bits are ignored.
- Not defined: all N bits are taken verbatim from msg_data. No CRC logic is synthesised.

## Test plan
- Reset: hold reset 5 cycles with msg_valid=1 → no accept; all outputs 0. One cycle after release, msg_ready=1.
- Long frame, SPC=10, amplitude=0x7000, msg_data=0x8D4840D6202CC371C32CE0576098:
  - Preamble samples 0–9, 20–29, 70–79 and 90–99 equal 0x7000; all other preamble samples are 0.
  - 2400 active samples.
  - Decoded bits match msg_data.
  - done occurs at sample 2399.
- Short frame, msg_long=0, msg_data[111:56]=0x5D4840D6ABCDEF:
  - 1280 active samples.
  - First data bit is 0, so samples 160–169 are 0 and samples 170–179 are 0x7000.
  - msg_ready=0 throughout.
- Back-to-back: msg_valid held high for two messages with GAP_CHIPS=8 → exactly 80 zero samples between frames; the second message is accepted only after the gap.
- Reset asserted at sample 500 of a long frame → outputs 0 on the next edge, done never pulses, msg_ready=1 after release.
- With MODE_S_TX_PARITY_EN: send msg_data=0x8D4840D6202CC371C32CE0000000 → emitted last 24 bits equal 0x576098. Without the macro, the emitted last 24 bits equal 0x000000.
